// File: rtl/rx_fifo.sv
// Receive-side byte FIFO with first-word fall-through output and sticky
// overrun/underrun flags; flush clears pointers and flags but leaves memory alone.
module rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    w_enable,
  input  logic [DATA_W-1:0]       w_data,
  input  logic                    r_enable,
  input  logic                    flush,
  output logic [DATA_W-1:0]       r_data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overrun,
  output logic                    underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              r_overrun;
  logic              r_underrun;

  logic              w_wr_ok;
  logic              w_rd_ok;

  assign empty    = (r_count == '0);
  assign full     = (r_count == FULL_CNT);
  assign count    = r_count;
  assign overrun  = r_overrun;
  assign underrun = r_underrun;

  // Gating r_data while empty keeps stale entries hidden after a flush.
  assign r_data   = empty ? '0 : r_mem[r_rptr];

  assign w_wr_ok  = w_enable && !flush && !full;
  assign w_rd_ok  = r_enable && !flush && !empty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_mem[r_wptr] <= w_data;
        r_wptr        <= r_wptr + PTR_ONE;
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_enable && full) begin
        r_overrun <= 1'b1;
      end
      if (r_enable && empty) begin
        r_underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: table-driven vectors, directed corner
// sequences and a randomized run, all compared against a queue-based model.
module tb_rx_fifo;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              w_enable;
  logic [DATA_W-1:0] w_data;
  logic              r_enable;
  logic              flush;
  logic [DATA_W-1:0] r_data;
  logic              empty;
  logic              full;
  logic [3:0]        count;
  logic              overrun;
  logic              underrun;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mQ[$];
  logic              mOv;
  logic              mUn;

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       re;
    logic       fl;
    int         cnt;
    logic [7:0] rd;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vecs[$];

  rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .w_enable (w_enable),
    .w_data   (w_data),
    .r_enable (r_enable),
    .flush    (flush),
    .r_data   (r_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overrun  (overrun),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mOv = 1'b0;
    mUn = 1'b0;
  endtask

  // Behavioural rules: decisions use the occupancy seen before the edge.
  task automatic modelStep(input logic we, input logic [7:0] wd, input logic re, input logic fl);
    bit wasFull, wasEmpty;
    if (fl) begin
      modelReset();
    end else begin
      wasFull  = (mQ.size() == DEPTH);
      wasEmpty = (mQ.size() == 0);
      if (we && wasFull)  mOv = 1'b1;
      if (re && wasEmpty) mUn = 1'b1;
      if (re && !wasEmpty) void'(mQ.pop_front());
      if (we && !wasFull)  mQ.push_back(wd);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] expRd;
    expRd = (mQ.size() != 0) ? mQ[0] : 8'h00;
    checkVal({tag, ".count"},    32'(count),    32'(mQ.size()));
    checkVal({tag, ".empty"},    32'(empty),    32'(mQ.size() == 0));
    checkVal({tag, ".full"},     32'(full),     32'(mQ.size() == DEPTH));
    checkVal({tag, ".r_data"},   32'(r_data),   32'(expRd));
    checkVal({tag, ".overrun"},  32'(overrun),  32'(mOv));
    checkVal({tag, ".underrun"}, 32'(underrun), 32'(mUn));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
  task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic re,
                               input logic fl, input string tag);
    w_enable = we;
    w_data   = wd;
    r_enable = re;
    flush    = fl;
    modelStep(we, wd, re, fl);
    @(posedge clk);
    #1;
    w_enable = 1'b0;
    r_enable = 1'b0;
    flush    = 1'b0;
    checkOutput(tag);
  endtask

  task automatic fillBytes(input int n, input logic [7:0] first, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, first + 8'(i), 1'b0, 1'b0, tag);
    end
  endtask

  initial begin
    n_rst    = 1'b0;
    w_enable = 1'b0;
    w_data   = '0;
    r_enable = 1'b0;
    flush    = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_during");
    checkVal("reset_during.count_const", 32'(count), 32'd0);
    #12;
    n_rst = 1'b1;
    #1;
    checkOutput("reset_after");

    // Table of expected outputs written straight from the requirements.
    vecs.push_back('{1'b1, 8'hA5, 1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h3C, 1'b0, 1'b0, 2, 8'hA5, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 3, 8'hA5, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'h3C, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'hFF, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h5A, 1'b1, 1'b0, 1, 8'h5A, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h99, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0});
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].fl, $sformatf("vec%0d", i));
      checkVal($sformatf("vec%0d.tbl_count", i),  32'(count),    32'(vecs[i].cnt));
      checkVal($sformatf("vec%0d.tbl_rdata", i),  32'(r_data),   32'(vecs[i].rd));
      checkVal($sformatf("vec%0d.tbl_ov", i),     32'(overrun),  32'(vecs[i].ov));
      checkVal($sformatf("vec%0d.tbl_un", i),     32'(underrun), 32'(vecs[i].un));
    end

    // Fill, overflow write, then drain in order.
    fillBytes(8, 8'h01, "fill8");
    checkVal("fill8.full_const", 32'(full), 32'd1);
    applyStimulus(1'b1, 8'h09, 1'b0, 1'b0, "ninth_write");
    checkVal("ninth_write.ov_const", 32'(overrun), 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkVal($sformatf("drain%0d.data_const", i), 32'(r_data), 32'(i + 1));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    end
    checkVal("drain.empty_const", 32'(empty), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "flush1");

    // Simultaneous read and write while full: the write is lost.
    fillBytes(8, 8'h01, "refill8");
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, "full_wr_rd");
    checkVal("full_wr_rd.count_const", 32'(count), 32'd7);
    checkVal("full_wr_rd.rdata_const", 32'(r_data), 32'h02);
    for (int i = 0; i < 7; i++) begin
      checkVal("no77", 32'(r_data == 8'h77), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain77");
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "flush2");

    // Pointer wrap through interleaved single-entry traffic.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, "wrap_w");
      checkVal($sformatf("wrap%0d.data_const", i), 32'(r_data), 32'(8'h10 + 8'(i)));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "wrap_r");
    end

    // Partially filled: concurrent read and write keeps count.
    fillBytes(3, 8'h40, "part3");
    applyStimulus(1'b1, 8'hC1, 1'b1, 1'b0, "part_wr_rd");
    checkVal("part_wr_rd.count_const", 32'(count), 32'd3);

    // Flush with overrun set and a concurrent write, then async reset mid-stream.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "flush3");
    fillBytes(8, 8'hE0, "fill_ov");
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, "set_ov");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "to5");
    checkVal("to5.count_const", 32'(count), 32'd5);
    applyStimulus(1'b1, 8'hAB, 1'b0, 1'b1, "flush_we");
    checkVal("flush_we.ov_const", 32'(overrun), 32'd0);
    fillBytes(3, 8'h61, "pre_rst");
    #2;
    n_rst = 1'b0;
    modelReset();
    #1;
    checkOutput("mid_reset");
    checkVal("mid_reset.empty_const", 32'(empty), 32'd1);
    #2;
    n_rst = 1'b1;
    applyStimulus(1'b1, 8'h3D, 1'b0, 1'b0, "post_rst_w");
    checkVal("post_rst_w.data_const", 32'(r_data), 32'h3D);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "post_rst_r");

    // Randomized traffic: write-heavy then read-heavy phases.
    for (int i = 0; i < 400; i++) begin
      logic we, re, fl;
      if (i < 200) begin
        we = ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 3) == 0);
      end else begin
        we = ($urandom_range(0, 3) == 0);
        re = ($urandom_range(0, 3) != 0);
      end
      fl = ($urandom_range(0, 31) == 0);
      applyStimulus(we, 8'($urandom), re, fl, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
